lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- MEM-stage load/store unit. Takes one load or store per handshake from EX and drives the data-memory request/grant/rvalid interface.
- For loads, extracts and sign- or zero-extends the addressed byte, half or word. Returns the result as registered `memdata` plus a valid strobe to the write-back mux.
- Stalls the pipeline while a memory access is outstanding. Flags misaligned accesses and memory timeouts.

Parameters:
- `MAX_WAIT`, default 255: cycles allowed in REQ plus WAIT_R before the access is aborted. Must be ≥ 2.
- `CNT_W`, default 8: width of the wait counter. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ex_valid`  in  1  EX presents an operation.
- `ex_ready`  out  1  unit can accept; high only in IDLE.
- `ex_is_load`  in  1  operation is a load.
- `ex_is_store`  in  1  operation is a store.
- `ex_funct3`  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `ex_addr`  in  32  byte address.
- `ex_wdata`  in  32  store data, right-aligned.
- `ex_rd`  in  5  load destination register.
- `dm_req`  out  1  memory request.
- `dm_addr`  out  32  word-aligned address (`ex_addr` & ~3).
- `dm_we`  out  4  byte write enables; 0000 for loads.
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_gnt`  in  1  memory accepts the request this cycle.
- `dm_rvalid`  in  1  read data valid.
- `dm_rdata`  in  32  read data.
- `wb_valid`  out  1  one-cycle strobe: load result ready.
- `wb_rd`  out  5  destination register for the result.
- `memdata`  out  32  extended load data.
- `stall`  out  1  pipeline hold; equals !`ex_ready` or an accept this cycle.
- `misalign_err`  out  1  one-cycle pulse.
- `timeout_err`  out  1  one-cycle pulse.

Behaviour:
- **Reset:** state IDLE. `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `wb_valid`, `wb_rd`, `memdata`, `misalign_err`, `timeout_err` all 0; counter 0.
  - Reset asserted mid-access drops `dm_req` at the next edge.
  - `dm_rvalid` seen in IDLE is ignored.
- **Accept:** an edge with `ex_valid` & `ex_ready` & (`ex_is_load` | `ex_is_store`). `ex_valid` with neither flag set is a no-op. Both flags set is treated as a load.
- **Misalignment:**
  - Half access with `addr[0]`=1, or word access with `addr[1:0]`≠0, is consumed without a memory request.
  - `misalign_err`=1 for the cycle after the accept; state stays IDLE.
- **States:**
  - **IDLE:** a legal accept latches addr, byte offset, funct3, rd and lane data, then goes to REQ. `dm_req` is registered and rises the cycle after the accept.
  - **REQ:** hold `dm_req` and the request fields stable until `dm_gnt`. On grant: a store goes to IDLE; a load goes to WAIT_R.
  - **WAIT_R:** on `dm_rvalid`, register the extended data into `memdata`, set `wb_valid`=1 and `wb_rd`, then go to IDLE. `wb_valid` is high exactly one cycle.
  - `dm_rvalid` is never sampled in REQ; the memory returns data no earlier than the cycle after the grant.
- **Timeout:**
  - The counter clears on accept and increments every cycle in REQ/WAIT_R.
  - When it reaches `MAX_WAIT` without completion: drop `dm_req`, pulse `timeout_err`, return to IDLE. No `wb_valid` is produced.
- **Store lanes (little-endian):**
  - SB: `dm_wdata` = byte×4; `dm_we` = 0001 << `addr[1:0]`.
  - SH: `dm_wdata` = half×2; `dm_we` = 0011 or 1100 by `addr[1]`.
  - SW: `dm_wdata` = data; `dm_we` = 1111.
- **Load extract:**
  - The byte lane is selected by the latched `addr[1:0]`; the half lane by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Undefined funct3 values are treated as LW.
- **Latency:**
  - Load with immediate grant and rvalid on the next cycle: `wb_valid` occurs 3 cycles after the accept edge.
  - Store with immediate grant: `ex_ready` returns 2 cycles after the accept.
- `memdata` holds its last value between loads.

Decomposition:
- `lsu_pkg`:
  - funct3 localparams: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - `lsu_state_t` enum: IDLE, REQ, WAIT_R.
  - Misalignment check function.
- One combinational sub-module, `lsu_load_align`: inputs rdata, offset, funct3; output 32-bit extended data. It is reused by the unit.

Test Plan:
- **Store byte:** SB addr 0x1003, wdata 0x000000AB, gnt on the first REQ cycle -> `dm_addr`=0x1000, `dm_we`=1000, `dm_wdata`=0xABABABAB. No `wb_valid`; `ex_ready` high again 2 cycles after the accept.
- **Signed load:** LB addr 0x2001, rdata 0x0000F000 -> `memdata`=0xFFFFFFF0, one `wb_valid` with `wb_rd` echoed. LBU with the same data -> 0x000000F0.
- **Grant wait states:** gnt held low 4 cycles then high; rvalid 2 cycles later; LHU addr 0x3002, rdata 0x8001_1234 -> `dm_req` and fields stable throughout, `stall` high, `memdata`=0x00008001.
- **Misaligned:** LW addr 0x4002 -> no `dm_req`, `misalign_err` pulse of 1 cycle, `ex_ready` stays 1.
- **Timeout:** `MAX_WAIT`=8, gnt never asserted -> `dm_req` drops after 8 cycles, `timeout_err` pulses, no `wb_valid`.
- **Reset mid-access:** `rst_n`=0 during WAIT_R, then rvalid arrives after release -> outputs zeroed, rvalid ignored, no `wb_valid`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R
  } lsu_state_t;

  // Unknown funct3 codes behave as word accesses, so they need full alignment.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B, F3_BU: is_misaligned = 1'b0;
      F3_H, F3_HU: is_misaligned = offset[0];
      default:     is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/grant/rvalid bus between the load/store unit and memory.
interface lsu_mem_stage_if;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_we;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_addr, dm_we, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_addr, dm_we, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half/word of a read word and extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one access per EX handshake, registered load
// result to write-back, misalignment and timeout detection.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic                   ex_is_load,
  input  logic                   ex_is_store,
  input  logic [2:0]             ex_funct3,
  input  logic [31:0]            ex_addr,
  input  logic [31:0]            ex_wdata,
  input  logic [4:0]             ex_rd,
  lsu_mem_stage_if.master        dm,
  output logic                   wb_valid,
  output logic [4:0]             wb_rd,
  output logic [31:0]            memdata,
  output logic                   stall,
  output logic                   misalign_err,
  output logic                   timeout_err
);

  lsu_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, memdata_q, memdata_d;
  logic [3:0]  we_q, we_d;
  logic [1:0]  offset_q, offset_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic        is_load_q, is_load_d;
  logic        wb_valid_q, wb_valid_d, misalign_q, misalign_d, timeout_q, timeout_d;

  logic        accept, misaligned, timed_out;
  logic [3:0]  store_we;
  logic [31:0] store_wdata, load_data;

  lsu_load_align u_align (
    .rdata  (dm.dm_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  assign ex_ready   = (state_q == IDLE);
  assign accept     = ex_valid && ex_ready && (ex_is_load || ex_is_store);
  assign stall      = !ex_ready || accept;
  assign misaligned = is_misaligned(ex_funct3, ex_addr[1:0]);
  assign timed_out  = (cnt_q >= CNT_W'(MAX_WAIT - 1));

  assign dm.dm_req   = (state_q == REQ);
  assign dm.dm_addr  = addr_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_wdata = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign memdata      = memdata_q;
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;

  // Little-endian lane replication so memory can pick any lane with dm_we.
  always_comb begin
    store_we    = 4'b1111;
    store_wdata = ex_wdata;
    case (ex_funct3)
      F3_B, F3_BU: begin
        store_we    = 4'b0001 << ex_addr[1:0];
        store_wdata = {4{ex_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        store_we    = ex_addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    offset_d   = offset_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    is_load_d  = is_load_q;
    memdata_d  = memdata_q;
    wb_rd_d    = wb_rd_q;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d   = REQ;
            addr_d    = {ex_addr[31:2], 2'b00};
            offset_d  = ex_addr[1:0];
            funct3_d  = ex_funct3;
            rd_d      = ex_rd;
            is_load_d = ex_is_load;
            we_d      = ex_is_load ? 4'b0000 : store_we;
            wdata_d   = store_wdata;
          end
        end
      end
      // A load granted on the final allowed cycle still times out.
      REQ: begin
        if (dm.dm_gnt && !is_load_q) begin
          state_d = IDLE;
        end else if (timed_out) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (dm.dm_gnt) state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (dm.dm_rvalid) begin
          state_d    = IDLE;
          memdata_d  = load_data;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
        end else if (timed_out) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
      offset_q   <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      is_load_q  <= 1'b0;
      memdata_q  <= '0;
      wb_rd_q    <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      offset_q   <= offset_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      is_load_q  <= is_load_d;
      memdata_q  <= memdata_d;
      wb_rd_q    <= wb_rd_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage with hand-computed expectations.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_addr = 32'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        ex_ready, wb_valid, stall, misalign_err, timeout_err;
  logic [4:0]  wb_rd;
  logic [31:0] memdata;

  int compared = 0;
  int mismatched = 0;

  lsu_mem_stage_if dm_bus ();

  lsu_mem_stage #(.MAX_WAIT(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_is_load   (ex_is_load),
    .ex_is_store  (ex_is_store),
    .ex_funct3    (ex_funct3),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .dm           (dm_bus),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .memdata      (memdata),
    .stall        (stall),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    ex_valid    = v;
    ex_is_load  = ld;
    ex_is_store = st;
    ex_funct3   = f3;
    ex_addr     = addr;
    ex_wdata    = wdata;
    ex_rd       = rd;
  endtask

  task automatic doStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] exp_we, input logic [31:0] exp_wdata);
    step();
    applyStimulus(1, 0, 1, f3, addr, wdata, 5'd0);
    sample();
    checkOutput("st_accept_stall", stall, 1);
    step();
    applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
    dm_bus.dm_gnt = 1'b1;
    sample();
    checkOutput("st_req", dm_bus.dm_req, 1);
    checkOutput("st_addr", dm_bus.dm_addr, addr & 32'hFFFF_FFFC);
    checkOutput("st_we", dm_bus.dm_we, exp_we);
    checkOutput("st_wdata", dm_bus.dm_wdata, exp_wdata);
    checkOutput("st_busy", ex_ready, 0);
    step();
    dm_bus.dm_gnt = 1'b0;
    sample();
    checkOutput("st_ready_back", ex_ready, 1);
    checkOutput("st_req_drop", dm_bus.dm_req, 0);
    checkOutput("st_no_wb", wb_valid, 0);
  endtask

  task automatic doLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic [31:0] exp);
    step();
    applyStimulus(1, 1, 0, f3, addr, 32'd0, rd);
    sample();
    step();
    applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
    dm_bus.dm_gnt = 1'b1;
    sample();
    checkOutput("ld_req", dm_bus.dm_req, 1);
    checkOutput("ld_we", dm_bus.dm_we, 0);
    checkOutput("ld_addr", dm_bus.dm_addr, addr & 32'hFFFF_FFFC);
    step();
    dm_bus.dm_gnt    = 1'b0;
    dm_bus.dm_rvalid = 1'b1;
    dm_bus.dm_rdata  = rdata;
    sample();
    checkOutput("ld_wb_early", wb_valid, 0);
    step();
    dm_bus.dm_rvalid = 1'b0;
    dm_bus.dm_rdata  = 32'd0;
    sample();
    checkOutput("ld_wb_valid", wb_valid, 1);
    checkOutput("ld_wb_rd", wb_rd, rd);
    checkOutput("ld_memdata", memdata, exp);
    step();
    sample();
    checkOutput("ld_wb_pulse", wb_valid, 0);
    checkOutput("ld_memdata_hold", memdata, exp);
  endtask

  initial begin
    dm_bus.dm_gnt    = 1'b0;
    dm_bus.dm_rvalid = 1'b0;
    dm_bus.dm_rdata  = 32'd0;

    repeat (3) step();
    sample();
    checkOutput("rst_req", dm_bus.dm_req, 0);
    checkOutput("rst_we", dm_bus.dm_we, 0);
    checkOutput("rst_addr", dm_bus.dm_addr, 0);
    checkOutput("rst_wdata", dm_bus.dm_wdata, 0);
    checkOutput("rst_wb", wb_valid, 0);
    checkOutput("rst_memdata", memdata, 0);
    checkOutput("rst_errs", {misalign_err, timeout_err}, 0);
    checkOutput("rst_ready", ex_ready, 1);
    step();
    rst_n = 1'b1;

    // ex_valid without a load/store flag must not start an access
    step();
    applyStimulus(1, 0, 0, F3_W, 32'h0000_0100, 32'd0, 5'd1);
    sample();
    checkOutput("noop_stall", stall, 0);
    step();
    applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
    sample();
    checkOutput("noop_req", dm_bus.dm_req, 0);
    checkOutput("noop_ready", ex_ready, 1);

    doStore(F3_B, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
    doStore(F3_B, 32'h0000_1000, 32'h0000_0055, 4'b0001, 32'h5555_5555);
    doStore(F3_H, 32'h0000_100A, 32'hCAFE_1234, 4'b1100, 32'h1234_1234);
    doStore(F3_W, 32'h0000_1004, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF);

    doLoad(F3_B,  32'h0000_2001, 5'd5,  32'h0000_F000, 32'hFFFF_FFF0);
    doLoad(F3_BU, 32'h0000_2001, 5'd6,  32'h0000_F000, 32'h0000_00F0);
    doLoad(F3_H,  32'h0000_2002, 5'd7,  32'h8001_1234, 32'hFFFF_8001);
    doLoad(F3_H,  32'h0000_2000, 5'd8,  32'h8001_7FFF, 32'h0000_7FFF);
    doLoad(F3_B,  32'h0000_2003, 5'd9,  32'h7F00_0000, 32'h0000_007F);
    doLoad(F3_W,  32'h0000_2004, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // LHU with four ungranted REQ cycles, then rvalid two cycles after grant
    step();
    applyStimulus(1, 1, 0, F3_HU, 32'h0000_3002, 32'd0, 5'd12);
    sample();
    for (int i = 0; i < 4; i++) begin
      step();
      applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
      sample();
      checkOutput("gw_req", dm_bus.dm_req, 1);
      checkOutput("gw_addr", dm_bus.dm_addr, 32'h0000_3000);
      checkOutput("gw_we", dm_bus.dm_we, 0);
      checkOutput("gw_stall", stall, 1);
    end
    step();
    dm_bus.dm_gnt = 1'b1;
    sample();
    checkOutput("gw_req_gnt", dm_bus.dm_req, 1);
    step();
    dm_bus.dm_gnt = 1'b0;
    sample();
    checkOutput("gw_wait_stall", stall, 1);
    checkOutput("gw_wait_noreq", dm_bus.dm_req, 0);
    step();
    dm_bus.dm_rvalid = 1'b1;
    dm_bus.dm_rdata  = 32'h8001_1234;
    sample();
    step();
    dm_bus.dm_rvalid = 1'b0;
    sample();
    checkOutput("gw_wb_valid", wb_valid, 1);
    checkOutput("gw_wb_rd", wb_rd, 5'd12);
    checkOutput("gw_memdata", memdata, 32'h0000_8001);

    // Misaligned word load and half store: consumed, no request
    step();
    applyStimulus(1, 1, 0, F3_W, 32'h0000_4002, 32'd0, 5'd3);
    sample();
    step();
    applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
    sample();
    checkOutput("mis_pulse", misalign_err, 1);
    checkOutput("mis_noreq", dm_bus.dm_req, 0);
    checkOutput("mis_ready", ex_ready, 1);
    step();
    sample();
    checkOutput("mis_pulse_end", misalign_err, 0);
    applyStimulus(1, 0, 1, F3_H, 32'h0000_4001, 32'h1111_2222, 5'd0);
    step();
    applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
    sample();
    checkOutput("mis_sh_pulse", misalign_err, 1);
    checkOutput("mis_sh_noreq", dm_bus.dm_req, 0);

    // Timeout: grant never comes, MAX_WAIT is 8
    step();
    applyStimulus(1, 1, 0, F3_W, 32'h0000_5000, 32'd0, 5'd4);
    sample();
    for (int i = 1; i <= 8; i++) begin
      step();
      applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
      sample();
      checkOutput("to_req_held", dm_bus.dm_req, 1);
      checkOutput("to_no_err_yet", timeout_err, 0);
    end
    step();
    sample();
    checkOutput("to_req_drop", dm_bus.dm_req, 0);
    checkOutput("to_pulse", timeout_err, 1);
    checkOutput("to_no_wb", wb_valid, 0);
    checkOutput("to_ready", ex_ready, 1);
    step();
    sample();
    checkOutput("to_pulse_end", timeout_err, 0);

    // Reset during WAIT_R, then a stale rvalid after release
    step();
    applyStimulus(1, 1, 0, F3_W, 32'h0000_6000, 32'd0, 5'd9);
    sample();
    step();
    applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0);
    dm_bus.dm_gnt = 1'b1;
    sample();
    step();
    dm_bus.dm_gnt = 1'b0;
    rst_n = 1'b0;
    sample();
    checkOutput("mr_in_wait", ex_ready, 0);
    step();
    rst_n = 1'b1;
    sample();
    checkOutput("mr_req", dm_bus.dm_req, 0);
    checkOutput("mr_memdata", memdata, 0);
    checkOutput("mr_addr", dm_bus.dm_addr, 0);
    checkOutput("mr_ready", ex_ready, 1);
    step();
    dm_bus.dm_rvalid = 1'b1;
    dm_bus.dm_rdata  = 32'h1234_5678;
    sample();
    step();
    dm_bus.dm_rvalid = 1'b0;
    sample();
    checkOutput("mr_no_wb", wb_valid, 0);
    checkOutput("mr_memdata_kept", memdata, 0);
    checkOutput("mr_wb_rd", wb_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
